// File: rtl/hazard_pkg.sv
// hazard_pkg: shared definitions for the pipeline hazard unit.
//   FSEL_*      - forwarding-select encodings driven onto the EX operand muxes
//   trk_ctl_t   - control bits of one tracker entry (the destination register
//                 number is kept beside it because its width is a parameter)
//   clog2       - ceiling log2, used for parameter checks at elaboration time
package hazard_pkg;

    localparam int FSEL_RF    = 0;  // operand comes from the register file
    localparam int FSEL_EXMEM = 1;  // operand comes from the EX/MEM stage output
    localparam int FSEL_MEMWB = 2;  // operand comes from the MEM/WB stage output

    typedef struct packed {
        logic valid;    // a real instruction occupies this stage
        logic wr_en;    // it writes its destination register
        logic is_load;  // its result arrives from data memory
    } trk_ctl_t;

    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// pipeline_hazard_unit_if: bundle between the ID stage / branch unit and the
// hazard unit.
//   ID side    : id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
//                id_wr_en, id_is_load, ex_branch_taken
//   unit side  : stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
// master = pipeline (drives instruction info), slave = hazard unit.
interface pipeline_hazard_unit_if #(
    parameter int REG_W  = 5,
    parameter int FSEL_W = 3,
    parameter int CNT_W  = 16
);
    logic              id_valid;
    logic [REG_W-1:0]  id_rs;
    logic [REG_W-1:0]  id_rt;
    logic              id_use_rs;
    logic              id_use_rt;
    logic [REG_W-1:0]  id_dst;
    logic              id_wr_en;
    logic              id_is_load;
    logic              ex_branch_taken;
    logic              stall;
    logic              flush;
    logic [FSEL_W-1:0] fwd_a;
    logic [FSEL_W-1:0] fwd_b;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    modport master (
        output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
               id_wr_en, id_is_load, ex_branch_taken,
        input  stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );

    modport slave (
        input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_dst,
               id_wr_en, id_is_load, ex_branch_taken,
        output stall, flush, fwd_a, fwd_b, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping.
//   clk, rst (sync, active-high), inc (count this cycle), count (value)
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (inc && !(&count_reg)) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;
endmodule

// File: rtl/pipeline_hazard_unit.sv
// pipeline_hazard_unit: forwarding / load-use / branch-flush controller.
//   clk, rst : clock and synchronous active-high reset
//   hz       : slave side of pipeline_hazard_unit_if
// Keeps a shift register of the destination registers of the DEPTH
// instructions past ID (index 0 = EX). stall and flush are combinational;
// the forwarding selects are registered so they line up with the instruction
// when it enters EX.
module pipeline_hazard_unit
    import hazard_pkg::*;
#(
    parameter int REG_W  = 5,
    parameter int DEPTH  = 3,
    parameter int FSEL_W = 3,
    parameter int CNT_W  = 16
) (
    input logic                  clk,
    input logic                  rst,
    pipeline_hazard_unit_if.slave hz
);
    typedef struct packed {
        trk_ctl_t         ctl;
        logic [REG_W-1:0] dst;
    } trk_entry_t;

    generate
        if (DEPTH < 2 || DEPTH > 7) begin : g_bad_depth
            $error("pipeline_hazard_unit: DEPTH out of range 2..7");
        end
        if (FSEL_W < clog2(DEPTH)) begin : g_bad_fsel
            $error("pipeline_hazard_unit: FSEL_W too narrow for DEPTH");
        end
    endgenerate

    trk_entry_t        trk_reg  [DEPTH];
    trk_entry_t        trk_next [DEPTH];
    logic [FSEL_W-1:0] fwd_a_reg, fwd_a_next;
    logic [FSEL_W-1:0] fwd_b_reg, fwd_b_next;
    logic              stall_int;
    logic              flush_int;

    // Register 0 never carries a real dependency.
    function automatic logic match(input trk_entry_t e, input logic [REG_W-1:0] src);
        return e.ctl.valid && e.ctl.wr_en && (e.dst == src) && (src != '0);
    endfunction

    always_comb begin
        flush_int = hz.ex_branch_taken;
        // A taken branch squashes ID anyway, so it suppresses the stall.
        stall_int = hz.id_valid && !flush_int && trk_reg[0].ctl.is_load &&
                    ((hz.id_use_rs && match(trk_reg[0], hz.id_rs)) ||
                     (hz.id_use_rt && match(trk_reg[0], hz.id_rt)));

        // Scan oldest to youngest so the youngest producer overwrites.
        // The last stage is skipped: the register file write-through covers it.
        fwd_a_next = FSEL_W'(FSEL_RF);
        fwd_b_next = FSEL_W'(FSEL_RF);
        for (int j = DEPTH - 2; j >= 0; j--) begin
            if (hz.id_use_rs && match(trk_reg[j], hz.id_rs)) begin
                fwd_a_next = FSEL_W'(j + 1);
            end
            if (hz.id_use_rt && match(trk_reg[j], hz.id_rt)) begin
                fwd_b_next = FSEL_W'(j + 1);
            end
        end
        if (stall_int || flush_int || !hz.id_valid) begin
            fwd_a_next = FSEL_W'(FSEL_RF);
            fwd_b_next = FSEL_W'(FSEL_RF);
        end

        // Stages below ID never freeze: shift every cycle, bubble on stall/flush.
        trk_next[0].ctl.valid   = hz.id_valid && !stall_int && !flush_int;
        trk_next[0].ctl.wr_en   = hz.id_wr_en;
        trk_next[0].ctl.is_load = hz.id_is_load;
        trk_next[0].dst         = hz.id_dst;
        for (int k = 1; k < DEPTH; k++) begin
            trk_next[k] = trk_reg[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                trk_reg[k] <= '0;
            end
            fwd_a_reg <= '0;
            fwd_b_reg <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                trk_reg[k] <= trk_next[k];
            end
            fwd_a_reg <= fwd_a_next;
            fwd_b_reg <= fwd_b_next;
        end
    end

    assign hz.stall = stall_int;
    assign hz.flush = flush_int;
    assign hz.fwd_a = fwd_a_reg;
    assign hz.fwd_b = fwd_b_reg;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall_int),
        .count (hz.stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (flush_int),
        .count (hz.flush_cnt)
    );
endmodule

// File: tb/tb_pipeline_hazard_unit.sv
module tb_pipeline_hazard_unit;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_checks;
    int   n_errors;

    pipeline_hazard_unit_if #(.REG_W(5), .FSEL_W(3), .CNT_W(16)) a_if ();
    pipeline_hazard_unit_if #(.REG_W(5), .FSEL_W(3), .CNT_W(4))  b_if ();

    pipeline_hazard_unit #(.REG_W(5), .DEPTH(3), .FSEL_W(3), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .hz  (a_if)
    );

    pipeline_hazard_unit #(.REG_W(5), .DEPTH(3), .FSEL_W(3), .CNT_W(4)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .hz  (b_if)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Order: valid, rs, use_rs, rt, use_rt, dst, wr_en, is_load, branch_taken
    task automatic drive_a(input logic v, input logic [4:0] rs, input logic urs,
                           input logic [4:0] rt, input logic urt, input logic [4:0] dst,
                           input logic wr, input logic ld, input logic br);
        a_if.id_valid        = v;
        a_if.id_rs           = rs;
        a_if.id_use_rs       = urs;
        a_if.id_rt           = rt;
        a_if.id_use_rt       = urt;
        a_if.id_dst          = dst;
        a_if.id_wr_en        = wr;
        a_if.id_is_load      = ld;
        a_if.ex_branch_taken = br;
        #1;
    endtask

    task automatic drive_b(input logic v, input logic [4:0] rs, input logic urs,
                           input logic [4:0] rt, input logic urt, input logic [4:0] dst,
                           input logic wr, input logic ld, input logic br);
        b_if.id_valid        = v;
        b_if.id_rs           = rs;
        b_if.id_use_rs       = urs;
        b_if.id_rt           = rt;
        b_if.id_use_rt       = urt;
        b_if.id_dst          = dst;
        b_if.id_wr_en        = wr;
        b_if.id_is_load      = ld;
        b_if.ex_branch_taken = br;
        #1;
    endtask

    task automatic nop_a();
        drive_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clear_a();
        repeat (3) begin
            nop_a();
            step();
        end
    endtask

    initial begin
        clk      = 1'b0;
        rst_a    = 1'b1;
        rst_b    = 1'b1;
        n_checks = 0;
        n_errors = 0;
        nop_a();
        drive_b(0, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        rst_a = 1'b0;
        #1;

        // Reset state
        check_eq("rst_fwd_a", 32'(a_if.fwd_a), 0);
        check_eq("rst_fwd_b", 32'(a_if.fwd_b), 0);
        check_eq("rst_stall_cnt", 32'(a_if.stall_cnt), 0);
        check_eq("rst_flush_cnt", 32'(a_if.flush_cnt), 0);
        check_eq("rst_stall", 32'(a_if.stall), 0);
        check_eq("rst_flush", 32'(a_if.flush), 0);

        // ADD r3 then consumer rs=r3: EX/MEM forward on A
        drive_a(1, 1, 1, 2, 1, 3, 1, 0, 0);
        step();
        drive_a(1, 3, 1, 4, 1, 6, 1, 0, 0);
        check_eq("add_add_stall", 32'(a_if.stall), 0);
        step();
        nop_a();
        check_eq("add_add_fwd_a", 32'(a_if.fwd_a), 1);
        check_eq("add_add_fwd_b", 32'(a_if.fwd_b), 0);

        // Producer r5, one unrelated, consumer rt=r5: MEM/WB forward on B
        clear_a();
        drive_a(1, 1, 1, 2, 1, 5, 1, 0, 0);
        step();
        drive_a(1, 10, 1, 11, 1, 9, 1, 0, 0);
        step();
        drive_a(1, 1, 1, 5, 1, 12, 1, 0, 0);
        step();
        nop_a();
        check_eq("gap1_fwd_b", 32'(a_if.fwd_b), 2);
        check_eq("gap1_fwd_a", 32'(a_if.fwd_a), 0);

        // Two unrelated in between: producer is in the last stage, no forward
        clear_a();
        drive_a(1, 1, 1, 2, 1, 5, 1, 0, 0);
        step();
        drive_a(1, 10, 1, 11, 1, 9, 1, 0, 0);
        step();
        drive_a(1, 10, 1, 11, 1, 8, 1, 0, 0);
        step();
        drive_a(1, 1, 1, 5, 1, 12, 1, 0, 0);
        step();
        nop_a();
        check_eq("gap2_fwd_b", 32'(a_if.fwd_b), 0);

        // LW r7 then consumer rs=r7: one stall cycle, bubble, then fwd_a=2
        clear_a();
        drive_a(1, 1, 1, 0, 0, 7, 1, 1, 0);
        step();
        drive_a(1, 7, 1, 8, 0, 10, 1, 0, 0);
        check_eq("lu_stall", 32'(a_if.stall), 1);
        check_eq("lu_flush", 32'(a_if.flush), 0);
        step();
        check_eq("lu_bubble_fwd_a", 32'(a_if.fwd_a), 0);
        check_eq("lu_bubble_fwd_b", 32'(a_if.fwd_b), 0);
        check_eq("lu_stall_cnt", 32'(a_if.stall_cnt), 1);
        check_eq("lu_stall_released", 32'(a_if.stall), 0);
        step();
        nop_a();
        check_eq("lu_fwd_a", 32'(a_if.fwd_a), 2);
        check_eq("lu_stall_cnt_hold", 32'(a_if.stall_cnt), 1);

        // Same pair with a taken branch in the hazard cycle: flush beats stall
        clear_a();
        drive_a(1, 1, 1, 0, 0, 7, 1, 1, 0);
        step();
        drive_a(1, 7, 1, 8, 0, 10, 1, 0, 1);
        check_eq("br_stall", 32'(a_if.stall), 0);
        check_eq("br_flush", 32'(a_if.flush), 1);
        step();
        check_eq("br_flush_cnt", 32'(a_if.flush_cnt), 1);
        check_eq("br_stall_cnt_unchanged", 32'(a_if.stall_cnt), 1);
        check_eq("br_fwd_a", 32'(a_if.fwd_a), 0);
        drive_a(1, 7, 1, 8, 0, 10, 1, 0, 0);
        check_eq("br_trk0_bubble_stall", 32'(a_if.stall), 0);
        check_eq("br_flush_low", 32'(a_if.flush), 0);
        step();
        nop_a();
        check_eq("br_after_fwd_a", 32'(a_if.fwd_a), 2);

        // Load into r0 then consumer of r0: no stall, no forward
        clear_a();
        drive_a(1, 1, 1, 2, 1, 0, 1, 1, 0);
        step();
        drive_a(1, 0, 1, 0, 1, 11, 1, 0, 0);
        check_eq("r0_stall", 32'(a_if.stall), 0);
        step();
        nop_a();
        check_eq("r0_fwd_a", 32'(a_if.fwd_a), 0);
        check_eq("r0_fwd_b", 32'(a_if.fwd_b), 0);

        // Two producers of r4: youngest (EX/MEM) wins on both operands
        clear_a();
        drive_a(1, 1, 1, 2, 1, 4, 1, 0, 0);
        step();
        drive_a(1, 2, 1, 3, 1, 4, 1, 0, 0);
        step();
        drive_a(1, 4, 1, 4, 1, 13, 1, 0, 0);
        step();
        nop_a();
        check_eq("young_fwd_a", 32'(a_if.fwd_a), 1);
        check_eq("young_fwd_b", 32'(a_if.fwd_b), 1);

        // rs and rt hit different stages
        clear_a();
        drive_a(1, 1, 1, 2, 1, 12, 1, 0, 0);
        step();
        drive_a(1, 1, 1, 2, 1, 13, 1, 0, 0);
        step();
        drive_a(1, 13, 1, 12, 1, 14, 1, 0, 0);
        step();
        nop_a();
        check_eq("split_fwd_a", 32'(a_if.fwd_a), 1);
        check_eq("split_fwd_b", 32'(a_if.fwd_b), 2);

        // Matching registers that the instruction does not read
        clear_a();
        drive_a(1, 1, 1, 2, 1, 13, 1, 0, 0);
        step();
        drive_a(1, 13, 0, 13, 0, 14, 1, 0, 0);
        step();
        nop_a();
        check_eq("nouse_fwd_a", 32'(a_if.fwd_a), 0);
        check_eq("nouse_fwd_b", 32'(a_if.fwd_b), 0);

        // Reset mid-stream with a load in trk[0]
        clear_a();
        drive_a(1, 1, 1, 0, 0, 7, 1, 1, 0);
        step();
        drive_a(1, 7, 1, 8, 0, 10, 1, 0, 0);
        check_eq("mid_rst_pre_stall", 32'(a_if.stall), 1);
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        #1;
        check_eq("mid_rst_stall", 32'(a_if.stall), 0);
        check_eq("mid_rst_fwd_a", 32'(a_if.fwd_a), 0);
        check_eq("mid_rst_stall_cnt", 32'(a_if.stall_cnt), 0);
        check_eq("mid_rst_flush_cnt", 32'(a_if.flush_cnt), 0);

        // CNT_W=4 instance: lw r7,0(r7) held in ID stalls every other cycle
        drive_b(1, 7, 1, 0, 0, 7, 1, 1, 0);
        step();
        rst_b = 1'b0;
        repeat (10) step();
        check_eq("sat_stall_cnt_mid", 32'(b_if.stall_cnt), 5);
        repeat (34) step();
        check_eq("sat_stall_cnt", 32'(b_if.stall_cnt), 15);
        drive_b(1, 7, 1, 0, 0, 7, 1, 1, 1);
        check_eq("sat_br_stall", 32'(b_if.stall), 0);
        check_eq("sat_br_flush", 32'(b_if.flush), 1);
        repeat (14) step();
        check_eq("sat_flush_cnt_mid", 32'(b_if.flush_cnt), 14);
        repeat (6) step();
        check_eq("sat_flush_cnt", 32'(b_if.flush_cnt), 15);
        check_eq("sat_stall_cnt_hold", 32'(b_if.stall_cnt), 15);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
- Parametrised forwarding and hazard controller for the MIPS integer pipeline.
- Supersedes the fixed two-source, two-stage forwarding logic.
- Tracks in-flight destination registers across DEPTH post-ID stages, producing registered forwarding selects, load-use stall, branch flush and saturating event counters.
- Sits beside the ID/EX register and drives its enable/bubble and the EX operand muxes.

Parameters:
- REG_W, 5, register-number width (2^REG_W architectural registers; register 0 is hardwired zero).
- DEPTH, 3, tracked stages after ID (index 0 = EX, 1 = MEM, 2 = WB); legal range 2..7.
- FSEL_W, 3, forwarding-select width; must satisfy 2^FSEL_W > DEPTH-1.
- CNT_W, 16, width of the stall and flush counters.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  REG_W  source A register.
- id_rt  in  REG_W  source B register.
- id_use_rs  in  1  instruction reads rs.
- id_use_rt  in  1  instruction reads rt.
- id_dst  in  REG_W  destination (already muxed rt/rd).
- id_wr_en  in  1  instruction writes id_dst.
- id_is_load  in  1  destination value arrives from data memory.
- ex_branch_taken  in  1  branch in EX resolved taken this cycle.
- stall  out  1  hold PC and IF/ID; inject bubble into EX.
- flush  out  1  discard IF/ID and ID instruction.
- fwd_a  out  FSEL_W  EX operand A source for the instruction currently in EX.
- fwd_b  out  FSEL_W  EX operand B source for the instruction currently in EX.
- stall_cnt  out  CNT_W  total stall cycles, saturating.
- flush_cnt  out  CNT_W  total flushes, saturating.

Behaviour:
- Tracker: trk[0..DEPTH-1] = {valid, dst, wr_en, is_load}; shifts every cycle (trk[k+1] <= trk[k]); trk[DEPTH-1] falls off. Pipeline never freezes below ID.
- trk[0] load rule:
  - flush or stall: bubble (valid=0).
  - otherwise: {id_valid, id_dst, id_wr_en, id_is_load}.
- Match(src, j): trk[j].valid & trk[j].wr_en & trk[j].dst==src & src!=0.
- stall (combinational) = id_valid & !ex_branch_taken & trk[0].is_load & (use_rs & Match(rs,0) | use_rt & Match(rt,0)).
- flush (combinational) = ex_branch_taken.
- Flush beats stall in the same cycle: no stall is counted; ID is squashed.
- Forwarding selects are registered and take effect the cycle the instruction occupies EX:
  - Encoding: 0 = register file; s = value of stage s output (1 = EX/MEM, 2 = MEM/WB, ...).
  - Next fwd_a = j+1 for the smallest j in 0..DEPTH-2 with Match(rs,j) & use_rs; 0 if none. Youngest producer wins. fwd_b likewise with rt.
  - On stall or flush, or if !id_valid, next fwd_a/fwd_b = 0 (bubble).
  - A producer in trk[DEPTH-1] is not forwarded; the register file write-through covers it.
- Latency: stall and flush are 0 cycles (combinational); fwd and tracker update is 1 cycle.
- Counters:
  - stall_cnt +1 per cycle with stall=1.
  - flush_cnt +1 per cycle with flush=1.
  - Both saturate at all-ones; no wrap.
- Reset (also mid-operation): all trk valid=0, fwd_a=fwd_b=0, both counters 0. stall/flush then depend only on inputs, so both are 0 unless ex_branch_taken=1.
- Back-to-back load-use: the stall lasts exactly one cycle because the load moves to trk[1]. The second cycle then forwards with sel=2.
- Simultaneous rs and rt hits on different stages are resolved independently.

Decomposition:
- Shared package hazard_pkg:
  - FSEL_RF=0, FSEL_EXMEM=1, FSEL_MEMWB=2 constants.
  - Tracker-entry struct typedef.
  - clog2 helper.
- One sub-module: sat_counter (CNT_W parametrised, inc, rst), instantiated twice.

Test Plan:
- ADD r3 (wr) then ADD using rs=r3 next cycle: stall=0; in EX, fwd_a=1, fwd_b=0.
- Producer r5, one unrelated instruction, then consumer rt=r5: fwd_b=2. With DEPTH=3 and a gap of 2 unrelated instructions: fwd_b=0.
- LW r7 followed by consumer rs=r7:
  - stall=1 for exactly 1 cycle; stall_cnt 0->1.
  - Consumer reaches EX one cycle later with fwd_a=2.
  - EX sees a bubble (fwd 0) in between.
- Same LW/consumer pair with ex_branch_taken=1 in the hazard cycle: stall=0, flush=1, flush_cnt=1, stall_cnt=0, next trk[0] invalid.
- Producer writes r0, consumer reads r0: fwd_a=0, stall=0. Two producers r4 in EX and MEM: consumer gets fwd=1 (youngest).
- Assert rst mid-stream with a load in trk[0]: next cycle fwd 0, counters 0, no stall. Hold stall for 2^CNT_W+5 cycles (CNT_W=4 build): stall_cnt stops at 15.
